ctrl2_bus_writer: RTL and testbench
===================================

CTRL2_BUS_WRITER -- requirements
Module: ctrl2_bus_writer

Interface
REQ-001 SHALL have parameter ADDR_LO, default 26'h2000104, meaning the bus address that carries the low half-word.
REQ-002 SHALL have parameter ADDR_HI, default 26'h2000106, meaning the bus address that carries the high half-word and commits the 32-bit word.
REQ-003 SHALL have parameter ADDR_IDLE, default 26'h0000000, meaning the non-matching address driven whenever no half-word is being presented.
REQ-004 SHALL have parameter HOLD, default 2, range 1..15, meaning the number of clocks each address/data pair is held on the bus.
REQ-005 SHALL have port Clock, input, 1, the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port Reset, input, 1; reset is synchronous and active-high.
REQ-007 SHALL have port WORD_IN, input, 32, the control word to be written.
REQ-008 SHALL have port VALID_IN, input, 1, the request qualifier for WORD_IN.
REQ-009 SHALL have port READY_OUT, output, 1, high when a request can be accepted.
REQ-010 SHALL have port ADDR_OUT, output, 26, the bus address, registered.
REQ-011 SHALL have port DATA_OUT, output, 16, the bus data, registered.
REQ-012 SHALL have port DONE_OUT, output, 1, a one-clock pulse when the high half-word hold completes.
REQ-013 SHALL have port WR_COUNT_OUT, output, 16, the count of completed word writes.

Function
REQ-014 SHALL accept a request on a rising edge where VALID_IN and READY_OUT are both 1, capturing WORD_IN into an internal word register.
REQ-015 SHALL hold READY_OUT at 1 only in state IDLE.
REQ-016 SHALL sequence through states IDLE -> LO -> HI -> GAP -> IDLE, and SHALL remain in IDLE while there is no accepted request.
REQ-017 SHALL, in LO, drive ADDR_OUT=ADDR_LO and DATA_OUT=word[15:0] for exactly HOLD clocks.
REQ-018 SHALL, in HI, drive ADDR_OUT=ADDR_HI and DATA_OUT=word[31:16] for exactly HOLD clocks.
REQ-019 SHALL, in GAP, drive ADDR_OUT=ADDR_IDLE and DATA_OUT=16'h0000 for exactly 1 clock.
REQ-020 SHALL, in IDLE, drive ADDR_OUT=ADDR_IDLE and DATA_OUT=16'h0000.
REQ-021 SHALL drive ADDR_LO on the clock after acceptance, giving an accept-to-bus latency of 1 clock.
REQ-022 SHALL never present ADDR_HI unless the ADDR_LO phase of the same word immediately preceded it.
REQ-023 SHALL take 2*HOLD+1 clocks from the first ADDR_LO clock to the return of READY_OUT=1.
REQ-024 SHALL pulse DONE_OUT in the GAP clock.
REQ-025 SHALL increment WR_COUNT_OUT in the GAP clock, wrapping from 16'hFFFF to 16'h0000.
REQ-026 SHALL ignore changes on WORD_IN and VALID_IN while not in IDLE; requests arriving then are neither queued nor acknowledged.
REQ-027 SHALL use a per-phase hold counter of 4 bits that is cleared on entry to each phase.
REQ-028 SHALL clamp HOLD=0 to 1 at elaboration.

Reset
REQ-029 SHALL, when Reset=1 on a rising edge, force state IDLE, ADDR_OUT=ADDR_IDLE, DATA_OUT=0, DONE_OUT=0, WR_COUNT_OUT=0, hold counter=0, and word register=0.
REQ-030 SHALL give Reset precedence over a simultaneous VALID_IN; that request is not accepted.
REQ-031 SHALL, on a Reset asserted during LO or HI, drive ADDR_IDLE on the next clock, with no DONE_OUT pulse and no count increment.
REQ-032 SHALL drive READY_OUT=1 on the first clock after Reset deasserts.

Structure
REQ-033 SHALL define the state encoding (IDLE=0, LO=1, HI=2, GAP=3) and the default ADDR_LO/ADDR_HI/ADDR_IDLE constants in a shared package afg_bus_pkg, so the bus decoders use the same addresses.
REQ-034 SHALL be a single flat module with no sub-modules; the FSM, hold counter and write counter are all local.

Verification
REQ-035 SHALL, with HOLD=2 and WORD_IN=32'hDEAD_BEEF accepted at cycle 0, show ADDR_LO/16'hBEEF in cycles 1-2, ADDR_HI/16'hDEAD in cycles 3-4, a GAP with DONE_OUT=1 in cycle 5, and READY_OUT=1 in cycle 6.
REQ-036 SHALL, with VALID_IN held high and words 32'h0000_0001 then 32'h0001_0000, show both accepted back-to-back 6 clocks apart, with WR_COUNT_OUT=2.
REQ-037 SHALL, with Reset asserted in the second LO clock, show ADDR_IDLE on the next clock, no ADDR_HI ever presented, WR_COUNT_OUT=0, and READY_OUT=1 after release.
REQ-038 SHALL, with WR_COUNT_OUT preset by 65535 writes and one more write, show WR_COUNT_OUT=16'h0000.
REQ-039 SHALL, in a closed loop with the 16-bit address-decoded control-register receiver and WORD_IN=32'h1234_5678, show the receiver's 32-bit control output equal to 32'h1234_5678 within 2 clocks after GAP.
REQ-040 SHALL, with HOLD=1 and VALID_IN pulsed during HI, show the pulse ignored, exactly one DONE_OUT pulse, and a 3-clock bus sequence.

Source files
------------

// File: rtl/afg_bus_pkg.sv
// Shared definitions for the AFG control bus: writer state encoding and the
// default decode addresses that the bus receivers also match against.
package afg_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_GAP  = 2'd3
    } wr_state_t;

    localparam logic [25:0] BUS_ADDR_LO   = 26'h2000104;
    localparam logic [25:0] BUS_ADDR_HI   = 26'h2000106;
    localparam logic [25:0] BUS_ADDR_IDLE = 26'h0000000;

    // Keeps the per-phase hold inside what a 4-bit counter can express.
    function automatic int unsigned hold_clamp(input int unsigned h);
        if (h == 0)
            return 1;
        else if (h > 15)
            return 15;
        else
            return h;
    endfunction

endpackage

// File: rtl/ctrl2_bus_writer.sv
// Writes a 32-bit control word onto the 16-bit AFG bus as two held
// half-word transfers (low then high), followed by a one-clock idle gap.
module ctrl2_bus_writer
    import afg_bus_pkg::*;
#(
    parameter logic [25:0] ADDR_LO   = BUS_ADDR_LO,
    parameter logic [25:0] ADDR_HI   = BUS_ADDR_HI,
    parameter logic [25:0] ADDR_IDLE = BUS_ADDR_IDLE,
    parameter int unsigned HOLD      = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] WORD_IN,
    input  logic        VALID_IN,
    output logic        READY_OUT,
    output logic [25:0] ADDR_OUT,
    output logic [15:0] DATA_OUT,
    output logic        DONE_OUT,
    output logic [15:0] WR_COUNT_OUT
);

    localparam logic [3:0] HOLD_LAST = 4'(hold_clamp(HOLD) - 1);

    wr_state_t   state;
    logic [3:0]  hold_cnt;
    logic [31:0] word;
    logic [25:0] addr;
    logic [15:0] data;
    logic        ready;
    logic        done;
    logic [15:0] wr_count;
    logic        hold_last;

    assign hold_last = (hold_cnt == HOLD_LAST);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ST_IDLE;
            hold_cnt <= 4'd0;
            word     <= 32'd0;
            addr     <= ADDR_IDLE;
            data     <= 16'h0000;
            ready    <= 1'b1;
            done     <= 1'b0;
            wr_count <= 16'h0000;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (VALID_IN && ready) begin
                        // Bus outputs load straight from WORD_IN so the low
                        // half appears on the clock right after acceptance.
                        word     <= WORD_IN;
                        state    <= ST_LO;
                        hold_cnt <= 4'd0;
                        addr     <= ADDR_LO;
                        data     <= WORD_IN[15:0];
                        ready    <= 1'b0;
                    end
                end
                ST_LO: begin
                    if (hold_last) begin
                        state    <= ST_HI;
                        hold_cnt <= 4'd0;
                        addr     <= ADDR_HI;
                        data     <= word[31:16];
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                ST_HI: begin
                    if (hold_last) begin
                        state    <= ST_GAP;
                        hold_cnt <= 4'd0;
                        addr     <= ADDR_IDLE;
                        data     <= 16'h0000;
                        done     <= 1'b1;
                        wr_count <= wr_count + 16'd1;
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                ST_GAP: begin
                    state    <= ST_IDLE;
                    hold_cnt <= 4'd0;
                    ready    <= 1'b1;
                end
                default: begin
                    state    <= ST_IDLE;
                    hold_cnt <= 4'd0;
                    addr     <= ADDR_IDLE;
                    data     <= 16'h0000;
                    ready    <= 1'b1;
                end
            endcase
        end
    end

    assign READY_OUT    = ready;
    assign ADDR_OUT     = addr;
    assign DATA_OUT     = data;
    assign DONE_OUT     = done;
    assign WR_COUNT_OUT = wr_count;

endmodule

// File: tb/tb_ctrl2_bus_writer.sv
// Bench for ctrl2_bus_writer: vector table, hand-written corner sequences and
// a randomized run against a schedule-based reference model.
module tb_ctrl2_bus_writer;
    import afg_bus_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // HOLD=2 instance
    logic        rst, valid, ready, done;
    logic [31:0] word;
    logic [25:0] addr;
    logic [15:0] data, wr_count;

    // HOLD=1 instance
    logic        rst1, valid1, ready1, done1;
    logic [31:0] word1;
    logic [25:0] addr1;
    logic [15:0] data1, wr_count1;

    ctrl2_bus_writer #(.HOLD(2)) dut (
        .Clock(clk), .Reset(rst), .WORD_IN(word), .VALID_IN(valid),
        .READY_OUT(ready), .ADDR_OUT(addr), .DATA_OUT(data),
        .DONE_OUT(done), .WR_COUNT_OUT(wr_count)
    );

    ctrl2_bus_writer #(.HOLD(1)) dut1 (
        .Clock(clk), .Reset(rst1), .WORD_IN(word1), .VALID_IN(valid1),
        .READY_OUT(ready1), .ADDR_OUT(addr1), .DATA_OUT(data1),
        .DONE_OUT(done1), .WR_COUNT_OUT(wr_count1)
    );

    // Address-decoded control-register receiver listening to the HOLD=2 bus.
    logic [15:0] rx_lo;
    logic [31:0] rx_ctrl;
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_lo   <= 16'h0;
            rx_ctrl <= 32'h0;
        end else if (addr == BUS_ADDR_LO) begin
            rx_lo <= data;
        end else if (addr == BUS_ADDR_HI) begin
            rx_ctrl <= {data, rx_lo};
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        v;
        logic [31:0] w;
        logic [25:0] a;
        logic [15:0] d;
        logic        rdy;
        logic        dn;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        saw_hi;
        int          done_pulses;
        int          pos, mcnt;
        logic [31:0] mw;
        logic        r, v;
        logic [31:0] wd;
        logic [25:0] ea;
        logic [15:0] ed;
        localparam int H = 2;
        localparam int N = 2 * H + 1;

        // Inputs during cycle i and the bus state expected on the clock after.
        // Rows 1-4 carry a request that must be ignored while busy.
        vecs[0] = '{1'b1, 32'hDEAD_BEEF, BUS_ADDR_LO,   16'hBEEF, 1'b0, 1'b0, 16'd0};
        vecs[1] = '{1'b1, 32'hFFFF_FFFF, BUS_ADDR_LO,   16'hBEEF, 1'b0, 1'b0, 16'd0};
        vecs[2] = '{1'b1, 32'h1111_2222, BUS_ADDR_HI,   16'hDEAD, 1'b0, 1'b0, 16'd0};
        vecs[3] = '{1'b1, 32'h3333_4444, BUS_ADDR_HI,   16'hDEAD, 1'b0, 1'b0, 16'd0};
        vecs[4] = '{1'b1, 32'h5555_6666, BUS_ADDR_IDLE, 16'h0000, 1'b0, 1'b1, 16'd1};
        vecs[5] = '{1'b0, 32'h7777_8888, BUS_ADDR_IDLE, 16'h0000, 1'b1, 1'b0, 16'd1};

        rst = 1'b1; valid = 1'b0; word = 32'h0;
        rst1 = 1'b1; valid1 = 1'b0; word1 = 32'h0;
        step();
        // Reset precedence over a simultaneous request
        valid = 1'b1; word = 32'hABCD_0123;
        step();
        check("rst_addr", 32'(addr), 32'(BUS_ADDR_IDLE));
        check("rst_data", 32'(data), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_cnt", 32'(wr_count), 32'h0);
        valid = 1'b0;
        rst = 1'b0; rst1 = 1'b0;
        step();
        check("post_rst_ready", 32'(ready), 32'h1);
        check("post_rst_addr", 32'(addr), 32'(BUS_ADDR_IDLE));
        check("post_rst_ready1", 32'(ready1), 32'h1);
        check("post_rst_cnt1", 32'(wr_count1), 32'h0);

        for (int i = 0; i < 6; i++) begin
            valid = vecs[i].v;
            word  = vecs[i].w;
            step();
            check($sformatf("vec%0d_addr", i), 32'(addr), 32'(vecs[i].a));
            check($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].d));
            check($sformatf("vec%0d_ready", i), 32'(ready), 32'(vecs[i].rdy));
            check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].dn));
            check($sformatf("vec%0d_cnt", i), 32'(wr_count), 32'(vecs[i].cnt));
        end
        valid = 1'b0;

        // Back-to-back acceptance with VALID held high
        rst = 1'b1; step(); rst = 1'b0; step();
        valid = 1'b1; word = 32'h0000_0001;
        step();
        check("b2b_first_addr", 32'(addr), 32'(BUS_ADDR_LO));
        check("b2b_first_data", 32'(data), 32'h0001);
        word = 32'h0001_0000;
        repeat (4) step();
        check("b2b_gap_done", 32'(done), 32'h1);
        step();
        check("b2b_idle_ready", 32'(ready), 32'h1);
        step();
        check("b2b_second_addr", 32'(addr), 32'(BUS_ADDR_LO));
        check("b2b_second_data", 32'(data), 32'h0000);
        valid = 1'b0;
        step(); step();
        check("b2b_second_hi", 32'(data), 32'h0001);
        step(); step();
        check("b2b_cnt", 32'(wr_count), 32'h2);

        // Reset in the second LO clock
        rst = 1'b1; step(); rst = 1'b0; step();
        saw_hi = 1'b0;
        valid = 1'b1; word = 32'hA5A5_5A5A;
        step();
        valid = 1'b0;
        step();
        if (addr == BUS_ADDR_HI) saw_hi = 1'b1;
        rst = 1'b1;
        step();
        check("abort_addr", 32'(addr), 32'(BUS_ADDR_IDLE));
        check("abort_done", 32'(done), 32'h0);
        rst = 1'b0;
        step();
        check("abort_ready", 32'(ready), 32'h1);
        for (int k = 0; k < 6; k++) begin
            if (addr == BUS_ADDR_HI) saw_hi = 1'b1;
            step();
        end
        check("abort_no_hi", 32'(saw_hi), 32'h0);
        check("abort_cnt", 32'(wr_count), 32'h0);

        // Closed loop with the receiver
        valid = 1'b1; word = 32'h1234_5678;
        step();
        valid = 1'b0;
        for (int k = 0; k < 20 && !done; k++) step();
        check("rx_done_seen", 32'(done), 32'h1);
        step(); step();
        check("rx_ctrl", rx_ctrl, 32'h1234_5678);

        // HOLD=1 with a request pulsed during HI
        valid1 = 1'b1; word1 = 32'hCAFE_F00D;
        step();
        check("h1_lo_addr", 32'(addr1), 32'(BUS_ADDR_LO));
        check("h1_lo_data", 32'(data1), 32'hF00D);
        valid1 = 1'b0;
        step();
        check("h1_hi_addr", 32'(addr1), 32'(BUS_ADDR_HI));
        check("h1_hi_data", 32'(data1), 32'hCAFE);
        valid1 = 1'b1; word1 = 32'h1111_2222;
        step();
        valid1 = 1'b0;
        check("h1_gap_addr", 32'(addr1), 32'(BUS_ADDR_IDLE));
        done_pulses = done1 ? 1 : 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (done1) done_pulses++;
            if (addr1 != BUS_ADDR_IDLE) done_pulses += 100;
        end
        check("h1_done_pulses", 32'(done_pulses), 32'h1);
        check("h1_cnt", 32'(wr_count1), 32'h1);

        // Count wrap: preset to FFFF, then one more write
        force dut1.wr_count = 16'hFFFF;
        #2;
        release dut1.wr_count;
        #1;
        check("wrap_preset", 32'(wr_count1), 32'hFFFF);
        valid1 = 1'b1; word1 = 32'h0BAD_F00D;
        step();
        valid1 = 1'b0;
        step(); step();
        check("wrap_done", 32'(done1), 32'h1);
        check("wrap_cnt", 32'(wr_count1), 32'h0000);

        // Randomized run on the HOLD=2 instance against a schedule model:
        // pos counts clocks since acceptance (0 = idle, N = gap clock).
        rst = 1'b1; step(); rst = 1'b0; step();
        pos = 0; mcnt = 0; mw = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            r  = ($urandom_range(0, 63) == 0);
            v  = ($urandom_range(0, 2) != 0);
            wd = $urandom;
            rst = r; valid = v; word = wd;
            if (r) begin
                pos = 0; mcnt = 0;
            end else if (pos == 0) begin
                if (v) begin pos = 1; mw = wd; end
            end else if (pos == N) begin
                pos = 0;
            end else begin
                pos++;
                if (pos == N) mcnt = (mcnt + 1) % 65536;
            end
            if (pos == 0 || pos == N) begin
                ea = BUS_ADDR_IDLE; ed = 16'h0;
            end else if (pos <= H) begin
                ea = BUS_ADDR_LO; ed = mw[15:0];
            end else begin
                ea = BUS_ADDR_HI; ed = mw[31:16];
            end
            step();
            check("rnd_addr", 32'(addr), 32'(ea));
            check("rnd_data", 32'(data), 32'(ed));
            check("rnd_ready", 32'(ready), 32'(pos == 0));
            check("rnd_done", 32'(done), 32'(pos == N));
            check("rnd_cnt", 32'(wr_count), 32'(mcnt));
        end
        rst = 1'b0; valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
